fetch_pc_unit: RTL and testbench

Program counter register and instruction-fetch controller for the single-core RISC-V pipeline. The block holds the architectural PC and drives it to the PC adder, which returns PC+4. It issues word reads to the synchronous instruction memory and buffers the returned instructions in a 2-entry FIFO. It delivers {instruction, PC} pairs to decode over a valid/ready handshake, and branch/jump redirects flush the buffer and any in-flight fetch.

---
 rtl/fetch_pc_unit.sv | 122 ++++++++++++
 tb/tb_fetch_pc_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: architectural PC register and instruction-fetch controller.
// Issues word reads to a synchronous instruction memory, buffers returned
// words in a 2-entry FIFO and hands {instr, pc} pairs to decode over a
// valid/ready handshake. Redirects flush the buffer and any in-flight fetch.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc_o,
    input  logic [31:0] pc_plus4_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_target_i,
    input  logic        halt_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    input  logic        if_ready_i,
    output logic [31:0] if_instr_o,
    output logic [31:0] if_pc_o
);

    localparam logic [1:0] BOOT = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HALT = 2'd2;

    logic [1:0]  state, state_nxt;
    logic [31:0] pc;
    logic [31:0] pc_of_req;
    logic        inflight;
    logic [1:0]  count;
    logic        head;
    logic        tail;
    logic [31:0] buf_instr [2];
    logic [31:0] buf_pc    [2];

    logic        pop;
    logic        capture;
    logic        issue;
    logic [2:0]  occ_after_pop;

    assign pop        = if_valid_o && if_ready_i;
    // A redirect kills the response arriving this cycle.
    assign capture    = inflight && !redirect_valid_i;
    // Occupancy that the new request would join; pop <= count so no underflow.
    assign occ_after_pop = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign issue      = (state == RUN) && !redirect_valid_i && (occ_after_pop < 3'd2);

    // Tail slot: with one entry it is the slot after head, otherwise head.
    assign tail       = head ^ count[0];

    assign pc_o        = pc;
    assign imem_addr_o = pc;
    assign imem_req_o  = issue;
    assign if_valid_o  = (count != 2'd0);
    assign if_instr_o  = buf_instr[head];
    assign if_pc_o     = buf_pc[head];

    // Next-state logic: BOOT is a single cycle, halt_i toggles RUN/HALT.
    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:    state_nxt = RUN;
            RUN:     if (halt_i)  state_nxt = HALT;
            HALT:    if (!halt_i) state_nxt = RUN;
            default: state_nxt = BOOT;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= BOOT;
        else     state <= state_nxt;
    end

    // PC, in-flight tracking and request PC; redirect overrides everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= {RESET_PC[31:2], 2'b00};
            inflight  <= 1'b0;
            pc_of_req <= 32'h0;
        end else if (redirect_valid_i) begin
            pc       <= {redirect_target_i[31:2], 2'b00};
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pc        <= pc_plus4_i;
                pc_of_req <= pc;
            end
        end
    end

    // FIFO bookkeeping: head pointer and entry count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 2'd0;
            head  <= 1'b0;
        end else if (redirect_valid_i) begin
            count <= 2'd0;
            head  <= 1'b0;
        end else begin
            count <= count + {1'b0, capture} - {1'b0, pop};
            if (pop) head <= ~head;
        end
    end

    // FIFO storage: the returning word is written to the tail with its PC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                buf_instr[i] <= 32'h0;
                buf_pc[i]    <= 32'h0;
            end
        end else if (capture) begin
            buf_instr[tail] <= imem_rdata_i;
            buf_pc[tail]    <= pc_of_req;
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: scoreboard bench for fetch_pc_unit. The bench plays the
// PC adder and a synchronous instruction memory, queues every expected
// {instr, pc} at request time and compares on each decode handshake.
module tb_fetch_pc_unit;

    localparam logic [31:0] RPC = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_i;
    logic        redirect_valid_i = 1'b0;
    logic [31:0] redirect_target_i = 32'h0;
    logic        halt_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic        if_valid_o;
    logic        if_ready_i = 1'b1;
    logic [31:0] if_instr_o;
    logic [31:0] if_pc_o;

    fetch_pc_unit #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst),
        .pc_o(pc_o), .pc_plus4_i(pc_plus4_i),
        .redirect_valid_i(redirect_valid_i), .redirect_target_i(redirect_target_i),
        .halt_i(halt_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_rdata_i(imem_rdata_i),
        .if_valid_o(if_valid_o), .if_ready_i(if_ready_i),
        .if_instr_o(if_instr_o), .if_pc_o(if_pc_o)
    );

    always #5 clk = ~clk;

    // PC adder and synchronous instruction memory models.
    assign pc_plus4_i = pc_o + 32'd4;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
    endfunction

    logic [31:0] mem_addr_q = 32'h0;
    always @(posedge clk) mem_addr_q <= imem_addr_o;
    assign imem_rdata_i = instr_of(mem_addr_q);

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    logic [63:0] sb [$];
    logic [31:0] exp_addr = RPC;

    // Monitor: compare pops, flush on redirect, queue each issued request.
    always @(negedge clk) begin
        logic [63:0] e;
        if (rst) begin
            sb.delete();
            exp_addr = RPC;
        end else begin
            chk("addr_eq_pc", imem_addr_o, pc_o);
            if (if_valid_o && if_ready_i) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pop_pc", if_pc_o, 32'hxxxx_xxxx);
                end else begin
                    e = sb.pop_front();
                    chk("pop_instr", if_instr_o, e[63:32]);
                    chk("pop_pc", if_pc_o, e[31:0]);
                end
            end
            if (redirect_valid_i) begin
                chk("req_on_redirect", {31'b0, imem_req_o}, 32'd0);
                sb.delete();
                exp_addr = {redirect_target_i[31:2], 2'b00};
            end else if (imem_req_o) begin
                chk("req_addr", imem_addr_o, exp_addr);
                sb.push_back({instr_of(imem_addr_o), imem_addr_o});
                exp_addr = imem_addr_o + 32'd4;
            end
            chk("occupancy_le2", {31'b0, sb.size() <= 2}, 32'd1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called right after reset is released (cycle 0 = BOOT).
    task automatic startup_check();
        #1;
        chk("boot_req", {31'b0, imem_req_o}, 32'd0);
        step(); #1;
        chk("c1_req", {31'b0, imem_req_o}, 32'd1);
        chk("c1_addr", imem_addr_o, RPC);
        chk("c1_valid", {31'b0, if_valid_o}, 32'd0);
        step(); #1;
        chk("c2_addr", imem_addr_o, RPC + 32'd4);
        chk("c2_valid", {31'b0, if_valid_o}, 32'd0);
        step(); #1;
        chk("c3_valid", {31'b0, if_valid_o}, 32'd1);
        chk("c3_if_pc", if_pc_o, RPC);
        chk("c3_addr", imem_addr_o, RPC + 32'd8);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] held;
        #12;
        chk("rst_pc", pc_o, RPC);
        chk("rst_req", {31'b0, imem_req_o}, 32'd0);
        chk("rst_valid", {31'b0, if_valid_o}, 32'd0);
        chk("rst_instr", if_instr_o, 32'd0);
        chk("rst_if_pc", if_pc_o, 32'd0);
        step();
        rst = 1'b0;
        startup_check();
        repeat (4) step();

        // Backpressure: decode stalls for 6 cycles.
        if_ready_i = 1'b0;
        #1;
        held = pc_o;
        for (int i = 0; i < 6; i++) begin
            if (i != 0) begin step(); #1; end
            chk("bp_req", {31'b0, imem_req_o}, 32'd0);
            chk("bp_pc_hold", pc_o, held);
            chk("bp_valid", {31'b0, if_valid_o}, 32'd1);
        end
        step();
        if_ready_i = 1'b1;
        repeat (5) step();

        // Redirect with one entry buffered and one request in flight.
        if_ready_i = 1'b0;
        redirect_valid_i = 1'b1;
        redirect_target_i = 32'h0000_2002;
        step();
        redirect_valid_i = 1'b0;
        if_ready_i = 1'b1;
        #1;
        chk("rd_valid_n1", {31'b0, if_valid_o}, 32'd0);
        chk("rd_pc_n1", pc_o, 32'h0000_2000);
        chk("rd_req_n1", {31'b0, imem_req_o}, 32'd1);
        step(); #1;
        chk("rd_valid_n2", {31'b0, if_valid_o}, 32'd0);
        step(); #1;
        chk("rd_valid_n3", {31'b0, if_valid_o}, 32'd1);
        chk("rd_if_pc_n3", if_pc_o, 32'h0000_2000);
        repeat (4) step();

        // Redirect coinciding with a pop and an arriving response.
        redirect_valid_i = 1'b1;
        redirect_target_i = 32'h0000_3000;
        step();
        redirect_valid_i = 1'b0;
        #1;
        chk("rp_valid_n1", {31'b0, if_valid_o}, 32'd0);
        step();
        step(); #1;
        chk("rp_if_pc_n3", if_pc_o, 32'h0000_3000);
        repeat (3) step();

        // PC wrap through the top of the address space.
        redirect_valid_i = 1'b1;
        redirect_target_i = 32'hFFFF_FFF9;
        step();
        redirect_valid_i = 1'b0;
        #1;
        chk("wrap_a0", imem_addr_o, 32'hFFFF_FFF8);
        step(); #1;
        chk("wrap_a1", imem_addr_o, 32'hFFFF_FFFC);
        step(); #1;
        chk("wrap_a2", imem_addr_o, 32'h0000_0000);
        repeat (4) step();

        // Halt for 5 cycles while decode keeps draining.
        halt_i = 1'b1;
        step(); #1;
        held = pc_o;
        chk("halt_req", {31'b0, imem_req_o}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            chk("halt_req", {31'b0, imem_req_o}, 32'd0);
            chk("halt_pc", pc_o, held);
        end
        chk("halt_drained", {31'b0, if_valid_o}, 32'd0);
        step();
        halt_i = 1'b0;
        #1;
        chk("unhalt_r0_req", {31'b0, imem_req_o}, 32'd0);
        step(); #1;
        chk("unhalt_r1_req", {31'b0, imem_req_o}, 32'd1);
        chk("unhalt_r1_addr", imem_addr_o, held);
        repeat (4) step();

        // Asynchronous reset pulse between clock edges.
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'b0, if_valid_o}, 32'd0);
        chk("arst_req", {31'b0, imem_req_o}, 32'd0);
        chk("arst_pc", pc_o, RPC);
        step();
        rst = 1'b0;
        startup_check();

        // Random decode backpressure, scoreboard checks ordering.
        for (int i = 0; i < 40; i++) begin
            if_ready_i = 1'($urandom_range(0, 1));
            step();
        end
        if_ready_i = 1'b1;
        repeat (4) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
